// File: rtl/mmio_fabric.sv
// mmio_fabric: single-master MMIO bridge decoding fixed-size slave windows,
// with per-access ack timeout and saturating error logging.
module mmio_fabric #(
    parameter int          NSLV      = 4,
    parameter int          SLV_SHIFT = 12,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_be,
    input  logic                 m_en,
    input  logic                 m_rw,
    output logic [31:0]          m_rdata,
    output logic                 m_wait,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_en,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_be,
    output logic                 s_rw,
    input  logic [32*NSLV-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ack,
    output logic [7:0]           err_cnt,
    output logic [31:0]          err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  m_idx;
    logic [2:0]  idx_q;
    logic        hit;
    logic        ack_sel;
    logic [31:0] rdata_sel;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [15:0] cnt;
    logic        tmo;

    assign m_idx = m_addr[SLV_SHIFT+2:SLV_SHIFT];
    assign hit   = (m_addr[31:SLV_SHIFT+3] == BASE_ADDR[31:SLV_SHIFT+3]) &&
                   ({29'b0, m_idx} < 32'(NSLV));

    // Only the latched slave's ack and data are visible; others are ignored.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (idx_q == 3'(i)) begin
                ack_sel   = s_ack[i];
                rdata_sel = s_rdata[32*i +: 32];
            end
        end
    end

    assign tmo = (cnt == CNT_LAST) && !ack_sel;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (m_en) state_nxt = hit ? ACCESS : RESP;
            ACCESS:  if (ack_sel || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Error bookkeeping is written on the edge entering RESP so it is
    // already visible during the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_addr   <= '0;
            s_wdata  <= '0;
            s_be     <= '0;
            s_rw     <= 1'b0;
            idx_q    <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            err_cnt  <= '0;
            err_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_en) begin
                        if (hit) begin
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                            s_be    <= m_be;
                            s_rw    <= m_rw;
                            idx_q   <= m_idx;
                            cnt     <= '0;
                            err_q   <= 1'b0;
                            rdata_q <= '0;
                        end else begin
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                            err_addr <= m_addr;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_sel) begin
                        rdata_q <= s_rw ? '0 : rdata_sel;
                    end else if (cnt == CNT_LAST) begin
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        err_addr <= s_addr;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_en = '0;
        if (state == ACCESS) begin
            for (int unsigned i = 0; i < NSLV; i++) begin
                if (idx_q == 3'(i)) s_en[i] = 1'b1;
            end
        end
    end

    assign m_rdata = (state == RESP) ? rdata_q : '0;
    assign m_err   = (state == RESP) && err_q;
    assign m_wait  = m_en && (state != RESP);

endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric: directed transactions against mmio_fabric with a response
// scoreboard popped by an independent monitor.
module tb_mmio_fabric;

    localparam int NSLV    = 4;
    localparam int TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          m_addr;
    logic [31:0]          m_wdata;
    logic [3:0]           m_be;
    logic                 m_en;
    logic                 m_rw;
    logic [31:0]          m_rdata;
    logic                 m_wait;
    logic                 m_err;
    logic [NSLV-1:0]      s_en;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic [3:0]           s_be;
    logic                 s_rw;
    logic [32*NSLV-1:0]   s_rdata;
    logic [NSLV-1:0]      s_ack;
    logic [7:0]           err_cnt;
    logic [31:0]          err_addr;

    always #5 clk = ~clk;

    mmio_fabric #(
        .NSLV(NSLV),
        .SLV_SHIFT(12),
        .BASE_ADDR(32'h8000_0000),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_en(m_en), .m_rw(m_rw),
        .m_rdata(m_rdata), .m_wait(m_wait), .m_err(m_err),
        .s_en(s_en), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_rw(s_rw),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .err_cnt(err_cnt), .err_addr(err_addr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (!rst && m_en && !m_wait) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", m_rdata, m_err);
            end else begin
                e = exp_q.pop_front();
                check32("resp_rdata", m_rdata, e.rdata);
                check32("resp_err", {31'b0, m_err}, {31'b0, e.err});
            end
        end
    end

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after RESP.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic rw,
                       input int slot, input logic [31:0] sdata,
                       input int ack_at, input logic [3:0] noise,
                       input int drop_lo, input int drop_hi,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_en);
        logic [NSLV-1:0] en_mask;
        int              k;
        int              resp_k;
        int              en_cycles;
        logic            bad;
        resp_t           r;
        en_mask = '0;
        if (slot >= 0) en_mask[slot] = 1'b1;
        for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
        if (slot >= 0) s_rdata[32*slot +: 32] = sdata;
        m_addr  = addr;
        m_wdata = wdata;
        m_be    = be;
        m_rw    = rw;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        exp_q.push_back(r);
        k = 0; resp_k = -1; en_cycles = 0; bad = 1'b0;
        while (resp_k < 0 && k < 40) begin
            m_en  = !(k >= drop_lo && k <= drop_hi);
            s_ack = noise | ((ack_at > 0 && k == ack_at) ? en_mask : '0);
            @(negedge clk);
            if (s_en != '0) en_cycles++;
            if (m_en && !m_wait) begin
                resp_k = k;
            end else if (k >= 1 && en_mask != '0) begin
                if (s_en !== en_mask || s_addr !== addr || s_wdata !== wdata ||
                    s_be !== be || s_rw !== rw) bad = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        m_en  = 1'b0;
        s_ack = '0;
        check32("resp_latency", 32'(resp_k), 32'(exp_lat));
        check32("s_en_cycles", 32'(en_cycles), 32'(exp_en));
        if (en_mask != '0) check32("access_stable", {31'b0, bad}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_addr = '0; m_wdata = '0; m_be = '0; m_en = 1'b0; m_rw = 1'b0;
        s_rdata = '0; s_ack = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check32("rst_s_en", {28'b0, s_en}, 32'd0);
        check32("rst_m_rdata", m_rdata, 32'd0);
        check32("rst_m_err", {31'b0, m_err}, 32'd0);
        check32("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check32("rst_err_addr", err_addr, 32'd0);
        check32("rst_s_addr", s_addr, 32'd0);
        @(posedge clk); #1;

        // Read slave 2, ack on first access cycle
        txn(32'h8000_2004, 32'h0, 4'hF, 1'b0, 2, 32'h1234_5678, 1, 4'b0000, 1, 0,
            32'h1234_5678, 1'b0, 2, 1);
        // Write slave 1, ack after 5 cycles; write returns 0 data
        txn(32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1, 32'hFFFF_0001, 5, 4'b0000, 1, 0,
            32'h0, 1'b0, 6, 5);
        check32("err_cnt_after_write", {24'b0, err_cnt}, 32'd0);
        // Read slave 3 with other slaves acking continuously
        txn(32'h8000_3010, 32'h0, 4'hF, 1'b0, 3, 32'hCAFE_F00D, 3, 4'b0111, 1, 0,
            32'hCAFE_F00D, 1'b0, 4, 3);
        // Index beyond NSLV
        txn(32'h8000_5000, 32'h0, 4'hF, 1'b0, -1, 32'h0, 0, 4'b0000, 1, 0,
            32'h0, 1'b1, 1, 0);
        check32("err_cnt_idx_miss", {24'b0, err_cnt}, 32'd1);
        check32("err_addr_idx_miss", err_addr, 32'h8000_5000);
        // Upper address bits outside the region
        txn(32'h8000_8000, 32'h0, 4'hF, 1'b0, -1, 32'h0, 0, 4'b0000, 1, 0,
            32'h0, 1'b1, 1, 0);
        check32("err_cnt_base_miss", {24'b0, err_cnt}, 32'd2);
        check32("err_addr_base_miss", err_addr, 32'h8000_8000);
        // Timeout, non-selected slaves acking
        txn(32'h8000_0008, 32'h0, 4'hF, 1'b0, 0, 32'h1111_0000, 0, 4'b1110, 1, 0,
            32'h0, 1'b1, 9, 8);
        check32("err_cnt_timeout", {24'b0, err_cnt}, 32'd3);
        check32("err_addr_timeout", err_addr, 32'h8000_0008);
        // Ack in the final allowed cycle wins over the timeout
        txn(32'h8000_1FFC, 32'h0, 4'hF, 1'b0, 1, 32'h0BAD_CAFE, 8, 4'b0000, 1, 0,
            32'h0BAD_CAFE, 1'b0, 9, 8);
        check32("err_cnt_last_ack", {24'b0, err_cnt}, 32'd3);
        // m_en dropped for two access cycles does not abort
        txn(32'h8000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h5555_AAAA, 4, 4'b0000, 1, 2,
            32'h5555_AAAA, 1'b0, 5, 4);
        // 300 timeouts saturate the error counter
        for (int n = 0; n < 300; n++) begin
            txn(32'h8000_0040, 32'h0, 4'hF, 1'b0, 0, 32'h2222_0000, 0, 4'b0000, 1, 0,
                32'h0, 1'b1, 9, 8);
        end
        check32("err_cnt_saturated", {24'b0, err_cnt}, 32'd255);
        check32("err_addr_saturated", err_addr, 32'h8000_0040);

        // Reset in the 3rd access cycle together with an ack
        m_addr = 32'h8000_2000; m_wdata = 32'hFEED_0001; m_be = 4'hF; m_rw = 1'b0;
        s_rdata[64 +: 32] = 32'h7777_8888;
        m_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; s_ack = 4'b0100; m_en = 1'b0;
        @(negedge clk);
        check32("pre_rst_s_en", {28'b0, s_en}, 32'h4);
        @(posedge clk); #1;
        rst = 1'b0; s_ack = '0;
        @(negedge clk);
        check32("mid_rst_s_addr", s_addr, 32'd0);
        check32("mid_rst_s_wdata", s_wdata, 32'd0);
        check32("mid_rst_s_be", {28'b0, s_be}, 32'd0);
        check32("mid_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check32("mid_rst_err_addr", err_addr, 32'd0);
        for (int n = 0; n < 3; n++) begin
            check32("mid_rst_s_en", {28'b0, s_en}, 32'd0);
            check32("mid_rst_m_rdata", m_rdata, 32'd0);
            check32("mid_rst_m_err", {31'b0, m_err}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;

        txn(32'h8000_2004, 32'h0, 4'hF, 1'b0, 2, 32'h1234_5678, 1, 4'b0000, 1, 0,
            32'h1234_5678, 1'b0, 2, 1);
        check32("err_cnt_post_rst", {24'b0, err_cnt}, 32'd0);

        @(negedge clk);
        check32("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_fabric.md
MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 The block SHALL have the following parameters.
- NSLV, default 4, number of slave channels (1..8).
- SLV_SHIFT, default 12, log2 of the window size per slave.
- BASE_ADDR, default 32'h8000_0000, base of the peripheral region.
- TIMEOUT, default 255, maximum number of cycles to wait for a slave ack (1..65535).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be as follows (clock and reset first).
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_addr  in  32  master byte address
- m_wdata  in  32  master write data
- m_be  in  4  byte enables
- m_en  in  1  request; held high until the cycle after m_wait is seen low
- m_rw  in  1  1 = write, 0 = read
- m_rdata  out  32  read data, valid in the RESP cycle
- m_wait  out  1  stall to master
- m_err  out  1  error flag, valid in the RESP cycle
- s_en  out  NSLV  one-hot slave select
- s_addr  out  32  latched address
- s_wdata  out  32  latched write data
- s_be  out  4  latched byte enables
- s_rw  out  1  latched direction
- s_rdata  in  32*NSLV  slave read data; slave i occupies bits [32i+31:32i]
- s_ack  in  NSLV  per-slave completion
- err_cnt  out  8  saturating error count
- err_addr  out  32  address of the most recent error

Function
REQ-003 Decode: hit when m_addr[31:SLV_SHIFT+3] == BASE_ADDR[31:SLV_SHIFT+3] and idx = m_addr[SLV_SHIFT+2:SLV_SHIFT] < NSLV; anything else is a miss.
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-005 IDLE with m_en=1 and a hit: latch addr, wdata, be, rw and idx; assert s_en[idx] on the next cycle; clear the timeout counter; go to ACCESS.
REQ-006 IDLE with m_en=1 and a miss: set the error flag; go to RESP without asserting any s_en.
REQ-007 ACCESS: hold s_en[idx] and all s_* outputs stable.
- On s_ack[idx]=1: capture the s_rdata slice for idx (0 for writes); deassert s_en; go to RESP.
- s_ack from non-selected slaves SHALL be ignored.
REQ-008 ACCESS timeout: the counter increments every cycle without an ack. When the counter == TIMEOUT-1 and there is no ack: set the error flag; deassert s_en; go to RESP. An ack in that same cycle wins (no error).
REQ-009 RESP lasts exactly 1 cycle: m_wait=0; m_rdata = captured data (0 on error); m_err = error flag. Then go to IDLE.
REQ-010 m_wait SHALL be combinational: 1 when m_en=1 and state != RESP; otherwise 0.
REQ-011 Latency: hit with ack on the first ACCESS cycle gives RESP 2 cycles after the request is sampled in IDLE; a miss gives RESP 1 cycle after.
REQ-012 Every error SHALL increment err_cnt (saturating at 255) and load err_addr with the latched address, both in the RESP cycle.
REQ-013 m_en dropping during ACCESS SHALL NOT abort the transaction; the transaction completes and the RESP cycle still occurs.
REQ-014 Back-to-back transactions: a request seen in IDLE immediately after RESP SHALL be accepted with no extra bubble.

Reset
REQ-015 rst=1 for one cycle SHALL force the following, regardless of state (including mid-ACCESS):
- state=IDLE; s_en=0; counter=0.
- m_rdata=0; m_err=0.
- err_cnt=0; err_addr=0.
- s_addr, s_wdata, s_be, s_rw all 0.
An s_ack arriving in the reset cycle SHALL be discarded.

Verification
REQ-016 Read slave 2 at 0x8000_2004 with s_ack on the first ACCESS cycle and slave-2 data 0x1234_5678 -> s_en=4'b0100 for 1 cycle; RESP 2 cycles after accept; m_rdata=0x1234_5678; m_err=0.
REQ-017 Write 0x8000_1000 with be=4'b0011 and ack after 5 cycles -> s_wdata/s_be stable for all 5 cycles; m_err=0; err_cnt unchanged.
REQ-018 Access 0x8000_5000 (idx 5 >= NSLV=4) -> no s_en pulse; RESP 1 cycle later; m_err=1; m_rdata=0; err_cnt=1; err_addr=0x8000_5000.
REQ-019 TIMEOUT=8 with a slave that never acks -> s_en high for exactly 8 cycles; m_err=1. Repeat 300 times -> err_cnt saturates at 255.
REQ-020 Assert rst in the 3rd ACCESS cycle while s_ack arrives in that same cycle -> state IDLE; all outputs 0; no RESP cycle occurs.
